bcd2_gate_ctrl: RTL
===================

// Module: bcd2_gate_ctrl
// PURPOSE
//  Sequencer for the 2-digit BCD event counter (bcd2). Runs gated measurements: clears
//  the counter, enables it for a fixed window of GATE_CYCLES clocks, then latches its
//  8-bit BCD value. The latched value is held for display for HOLD_CYCLES clocks.
//  Sits between the system control logic and the bcd2 counter. Supports single-shot
//  and continuous repetition.
// PARAMETERS
//  GATE_CYCLES  100  counting window length in clk cycles; must be >= 1
//  HOLD_CYCLES  50   result display time before re-arm; 0 = skip HOLD
// PORTS
//  clk           in   1  system clock, rising edge
//  reset         in   1  asynchronous, active-high reset
//  start         in   1  level; sampled only in IDLE, starts one measurement
//  continuous    in   1  1 = re-arm automatically after HOLD
//  bcd_in        in   8  {tens,ones} BCD value from the bcd2 counter
//  cnt_clr       out  1  clear strobe to the bcd2 counter
//  cnt_en        out  1  count enable to the bcd2 counter
//  result        out  8  latched BCD measurement
//  result_valid  out  1  one-cycle pulse when result updates
//  busy          out  1  high in every state except IDLE
//  overflow      out  1  count wrapped past 99 during the last gate
// BEHAVIOUR
//  Reset: state=IDLE; result=8'h00; result_valid=0; overflow=0. cnt_clr, cnt_en and
//   busy decode to 0. Reset asserted mid-measurement aborts it immediately.
//  FSM (Moore): IDLE -> CLEAR -> GATE -> SETTLE -> LATCH -> HOLD -> {CLEAR | IDLE}
//   IDLE:   start=1 -> CLEAR on the next edge.
//   CLEAR:  1 cycle, cnt_clr=1; gate counter loaded with GATE_CYCLES-1.
//   GATE:   cnt_en=1 for exactly GATE_CYCLES cycles; down-counter reaching 0 -> SETTLE.
//   SETTLE: 1 cycle, cnt_en=0; lets the counter output settle.
//   LATCH:  result<=bcd_in; result_valid=1 on the following cycle, for 1 cycle.
//   HOLD:   HOLD_CYCLES cycles. At exit, continuous=1 -> CLEAR, else IDLE.
//           HOLD_CYCLES=0 means LATCH goes directly to the HOLD exit decision.
//  Latency: start seen in IDLE at edge N -> result_valid high in cycle N+GATE_CYCLES+4.
//  start while busy: ignored; no queueing.
//  Dropping continuous during GATE or HOLD: the current measurement completes, then
//   the FSM returns to IDLE.
//  Gate counter width: $clog2(GATE_CYCLES+1). The counter never wraps.
//  Wrap detect: in GATE, bcd_in going from 8'h99 to 8'h00 between consecutive cycles
//   sets the sticky wrap_seen flag. wrap_seen clears in CLEAR. overflow<=wrap_seen at LATCH.
//  bcd_in nibbles > 9 are passed through unchanged; no correction is applied.
// CONFIGURATION
//  BCD2_GATE_SAT_EN defined:   if wrap_seen at LATCH, result<=8'h99 (saturate) and
//   overflow=1.
//  BCD2_GATE_SAT_EN undefined: result<=raw bcd_in (wrapped value). overflow is still
//   reported.
// STRUCTURE
//  bcd2_pkg: state enum (IDLE, CLEAR, GATE, SETTLE, LATCH, HOLD); BCD_MAX=8'h99;
//   BCD_ZERO=8'h00.
//  Sub-module bcd_wrap_det: registers the previous bcd_in and outputs a wrap pulse
//   when prev==BCD_MAX && cur==BCD_ZERO && en.
//  Top level: FSM, gate/hold down-counter, result/overflow registers.
// TESTING (GATE_CYCLES=10, HOLD_CYCLES=4, bench model of bcd2 counting x pulses)
//  1. Reset held 20ns then released, start=0 -> busy=0, cnt_en=0, result=8'h00
//     indefinitely.
//  2. start pulse, x toggling every 15ns -> cnt_clr exactly 1 cycle, then cnt_en exactly
//     10 cycles; result_valid at cycle start+14; result equals the model count in BCD.
//  3. continuous=1, start held high -> back-to-back measurements with period
//     1+10+1+1+4=17 cycles; each result_valid pulse lasts 1 cycle.
//  4. Forced bcd_in sequence ..8'h98,8'h99,8'h00,8'h01 during GATE -> overflow=1;
//     result=8'h99 with BCD2_GATE_SAT_EN defined, 8'h01 without it.
//  5. reset asserted in cycle 5 of GATE -> same cycle: cnt_en=0, busy=0, result=8'h00;
//     after release, a new start runs a full 10-cycle gate.
//  6. start pulsed during GATE and HOLD with continuous=0 -> ignored; one result only,
//     then IDLE.

Source files
------------

// File: rtl/bcd2_pkg.sv
// bcd2_pkg: shared state encoding and BCD constants for the gated bcd2 measurement sequencer.
package bcd2_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, LATCH, HOLD} state_t;
    localparam logic [7:0] BCD_MAX  = 8'h99;
    localparam logic [7:0] BCD_ZERO = 8'h00;
endpackage

// File: rtl/bcd2_gate_ctrl_wrap_det.sv
// bcd_wrap_det: flags a 99 -> 00 roll-over of the bcd2 count between two consecutive enabled cycles.
module bcd_wrap_det
    import bcd2_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] cur,
    output logic       wrap
);
    logic [7:0] prev_q, prev_d;
    logic       en_q, en_d;
    always_comb begin
        prev_d = cur;
        en_d   = en;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= BCD_ZERO;
            en_q   <= 1'b0;
        end else begin
            prev_q <= prev_d;
            en_q   <= en_d;
        end
    end
    // Both samples must fall inside the window, so a stale 99 from before the clear is not a wrap.
    assign wrap = en && en_q && prev_q == BCD_MAX && cur == BCD_ZERO;
endmodule

// File: rtl/bcd2_gate_ctrl.sv
// bcd2_gate_ctrl: clears, gates and latches the bcd2 counter in single-shot or continuous mode.
// Define BCD2_GATE_SAT_EN to saturate the latched result at 8'h99 when the count wrapped.
module bcd2_gate_ctrl
    import bcd2_pkg::*;
#(
    parameter int GATE_CYCLES = 100,
    parameter int HOLD_CYCLES = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       continuous,
    input  logic [7:0] bcd_in,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic       overflow
);
    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int CW = GW > HW ? GW : HW;
    localparam logic [CW-1:0] GATE_LOAD = CW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
    state_t        state_q, state_d, hold_exit;
    logic [CW-1:0] cnt_q, cnt_d, cnt_dec;
    logic [7:0]    result_q, result_d;
    logic          result_valid_q, result_valid_d;
    logic          overflow_q, overflow_d;
    logic          wrap_seen_q, wrap_seen_d;
    logic          wrap;
    bcd_wrap_det u_wrap (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .cur   (bcd_in),
        .wrap  (wrap)
    );
    assign cnt_dec   = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
    assign hold_exit = continuous ? CLEAR : IDLE;
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        overflow_d     = overflow_q;
        result_valid_d = 1'b0;
        wrap_seen_d    = wrap_seen_q | wrap;
        case (state_q)
            IDLE:   state_d = start ? CLEAR : IDLE;
            CLEAR: begin
                cnt_d       = GATE_LOAD;
                wrap_seen_d = 1'b0;
                state_d     = GATE;
            end
            GATE: begin
                cnt_d   = cnt_dec;
                state_d = cnt_q == '0 ? SETTLE : GATE;
            end
            SETTLE: state_d = LATCH;
            LATCH: begin
`ifdef BCD2_GATE_SAT_EN
                result_d = wrap_seen_q ? BCD_MAX : bcd_in;
`else
                result_d = bcd_in;
`endif
                overflow_d     = wrap_seen_q;
                result_valid_d = 1'b1;
                cnt_d          = HOLD_LOAD;
                state_d        = HOLD_CYCLES == 0 ? hold_exit : HOLD;
            end
            HOLD: begin
                cnt_d   = cnt_dec;
                state_d = cnt_q == '0 ? hold_exit : HOLD;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            result_q       <= BCD_ZERO;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            wrap_seen_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overflow_q     <= overflow_d;
            wrap_seen_q    <= wrap_seen_d;
        end
    end
    assign cnt_clr      = state_q == CLEAR;
    assign cnt_en       = state_q == GATE;
    assign busy         = state_q != IDLE;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;
endmodule
